switch_out_arbiter: RTL and testbench

- Schedules frames from the 4 input-side frame queues onto the 4 output ports of switchcore.
- Grants an input exclusive, atomic ownership of every output in its destination mask, including broadcast.
- Holds each output until its transmitter reports end-of-frame, then enforces an inter-frame gap.
- Sits between the MAC-lookup/input FIFOs and the output crossbar/TX muxes.

---
 rtl/switch_pkg.sv | 16 +
 rtl/switch_out_arbiter_if.sv | 26 ++
 rtl/out_port_fsm.sv | 45 ++++
 rtl/switch_out_arbiter.sv | 115 +++++++++++
 tb/tb_switch_out_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
// Shared types and sizing for the switchcore output arbiter.
package switch_pkg;

    localparam int NPORTS = 4;
    localparam int IDX_W  = $clog2(NPORTS);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } out_state_t;

    typedef logic [IDX_W-1:0]  port_idx_t;
    typedef logic [NPORTS-1:0] port_mask_t;

endpackage

// File: rtl/switch_out_arbiter_if.sv
// Request/grant and transmitter-status bundle between input queues, arbiter and TX side.
interface switch_out_arbiter_if;
    import switch_pkg::*;

    port_mask_t                link_sync;
    port_mask_t                req_valid;
    logic [NPORTS*NPORTS-1:0]  req_mask;
    port_mask_t                tx_done;
    port_mask_t                grant;
    port_mask_t                grant_mask;
    port_mask_t                drop;
    port_mask_t                out_busy;
    logic [NPORTS*IDX_W-1:0]   out_owner;
    logic                      err;

    modport slave (
        input  link_sync, req_valid, req_mask, tx_done,
        output grant, grant_mask, drop, out_busy, out_owner, err
    );

    modport master (
        output link_sync, req_valid, req_mask, tx_done,
        input  grant, grant_mask, drop, out_busy, out_owner, err
    );

endinterface

// File: rtl/out_port_fsm.sv
// Per-output reservation tracker: IDLE -> FRAME on grant -> GAP on tx_done -> IDLE after the gap.
module out_port_fsm
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       grant_set,
    input  logic       tx_done,
    input  logic [7:0] ifg_cycles,
    output logic       busy,
    output logic       err_pulse
);

    out_state_t state_reg;
    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_set) state_reg <= FRAME;
                end
                FRAME: begin
                    if (tx_done) begin
                        state_reg <= GAP;
                        count_reg <= ifg_cycles - 8'd1;
                    end
                end
                GAP: begin
                    // Counter stops at zero; the state leaves on the cycle it reads zero.
                    if (count_reg == 8'd0) state_reg <= IDLE;
                    else                   count_reg <= count_reg - 8'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign err_pulse = tx_done && (state_reg != FRAME);

endmodule

// File: rtl/switch_out_arbiter.sv
// Round-robin, all-or-nothing scheduler of input head frames onto output ports.
module switch_out_arbiter
    import switch_pkg::*;
#(
    parameter int IFG_CYCLES = 12
) (
    input  logic                clk,
    input  logic                reset,
    switch_out_arbiter_if.slave bus
);

    port_mask_t eff            [NPORTS];
    port_mask_t remaining_reg  [NPORTS];
    port_mask_t remaining_next [NPORTS];
    port_idx_t  owner_reg      [NPORTS];
    port_mask_t active_reg;
    port_mask_t out_busy;
    port_mask_t err_pulse;
    port_mask_t grant_set;
    port_mask_t grant_reg;
    port_mask_t grant_mask_reg;
    port_mask_t drop_reg;
    port_idx_t  rr_ptr_reg;
    port_idx_t  pick_idx;
    port_idx_t  scan_idx;
    logic       pick_found;
    logic       pick_grant;
    logic       err_reg;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            // Hairpin and link-down outputs are stripped before any decision.
            assign eff[gi] = bus.req_mask[gi*NPORTS +: NPORTS] & bus.link_sync
                             & ~(port_mask_t'(1) << gi);
            assign bus.out_owner[gi*IDX_W +: IDX_W] = owner_reg[gi];
            assign grant_set[gi] = pick_grant && eff[pick_idx][gi];

            always_comb begin
                remaining_next[gi] = remaining_reg[gi] & ~bus.tx_done;
                if (pick_grant && (pick_idx == port_idx_t'(gi)))
                    remaining_next[gi] = remaining_next[gi] | eff[gi];
            end

            out_port_fsm u_out_fsm (
                .clk        (clk),
                .reset      (reset),
                .grant_set  (grant_set[gi]),
                .tx_done    (bus.tx_done[gi]),
                .ifg_cycles (8'(IFG_CYCLES)),
                .busy       (out_busy[gi]),
                .err_pulse  (err_pulse[gi])
            );
        end
    endgenerate

    // An empty effective mask never overlaps busy outputs, so it wins the scan and becomes a drop.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            scan_idx = port_idx_t'((int'(rr_ptr_reg) + k) % NPORTS);
            if (!pick_found && bus.req_valid[scan_idx] && !active_reg[scan_idx]
                && ((eff[scan_idx] & out_busy) == '0)) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign pick_grant = pick_found && (eff[pick_idx] != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_reg      <= '0;
            grant_mask_reg <= '0;
            drop_reg       <= '0;
            active_reg     <= '0;
            rr_ptr_reg     <= '0;
            err_reg        <= 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                owner_reg[o]     <= '0;
                remaining_reg[o] <= '0;
            end
        end else begin
            grant_reg      <= '0;
            grant_mask_reg <= '0;
            drop_reg       <= '0;
            err_reg        <= err_reg | (|err_pulse);
            for (int i = 0; i < NPORTS; i++) begin
                remaining_reg[i] <= remaining_next[i];
                active_reg[i]    <= |remaining_next[i];
            end
            if (pick_found) begin
                rr_ptr_reg <= port_idx_t'((int'(pick_idx) + 1) % NPORTS);
                if (pick_grant) begin
                    grant_reg[pick_idx] <= 1'b1;
                    grant_mask_reg      <= eff[pick_idx];
                    for (int o = 0; o < NPORTS; o++) begin
                        if (eff[pick_idx][o]) owner_reg[o] <= pick_idx;
                    end
                end else begin
                    drop_reg[pick_idx] <= 1'b1;
                end
            end
        end
    end

    assign bus.grant      = grant_reg;
    assign bus.grant_mask = grant_mask_reg;
    assign bus.drop       = drop_reg;
    assign bus.out_busy   = out_busy;
    assign bus.err        = err_reg;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a cycle-timestamp reference model.
module tb_switch_out_arbiter;
    import switch_pkg::*;

    localparam int IFG = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    switch_out_arbiter_if bus_if ();

    switch_out_arbiter #(.IFG_CYCLES(IFG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: an output is reserved while in a frame or until its gap end timestamp.
    int              cyc = 0;
    bit              m_frame   [NPORTS];
    int              m_gap_end [NPORTS];
    bit [NPORTS-1:0] m_rem     [NPORTS];
    int              m_owner   [NPORTS];
    int              m_rr;
    bit              m_err;
    bit [NPORTS-1:0] m_grant, m_gmask, m_drop;

    function automatic bit [NPORTS-1:0] m_busy(int n);
        bit [NPORTS-1:0] b = '0;
        for (int o = 0; o < NPORTS; o++) b[o] = m_frame[o] || (n < m_gap_end[o]);
        return b;
    endfunction

    function automatic logic [NPORTS*IDX_W-1:0] m_owner_vec();
        logic [NPORTS*IDX_W-1:0] v = '0;
        for (int o = 0; o < NPORTS; o++) v[o*IDX_W +: IDX_W] = IDX_W'(m_owner[o]);
        return v;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NPORTS; o++) begin
            m_frame[o] = 0; m_gap_end[o] = 0; m_rem[o] = '0; m_owner[o] = 0;
        end
        m_rr = 0; m_err = 0; m_grant = '0; m_gmask = '0; m_drop = '0;
    endtask

    task automatic model_step();
        bit [NPORTS-1:0] busy_pre, eff, pick_eff;
        int pick = -1;
        cyc++;
        busy_pre = m_busy(cyc - 1);
        pick_eff = '0;
        m_grant = '0; m_gmask = '0; m_drop = '0;
        for (int k = 0; k < NPORTS; k++) begin
            int i = (m_rr + k) % NPORTS;
            eff = bus_if.req_mask[i*NPORTS +: NPORTS] & bus_if.link_sync & ~(4'b0001 << i);
            if (pick < 0 && bus_if.req_valid[i] && m_rem[i] == '0 && (eff & busy_pre) == '0) begin
                pick = i; pick_eff = eff;
            end
        end
        for (int o = 0; o < NPORTS; o++) begin
            if (bus_if.tx_done[o]) begin
                if (m_frame[o]) begin
                    m_frame[o] = 0;
                    m_gap_end[o] = cyc + IFG;
                    for (int i = 0; i < NPORTS; i++) m_rem[i][o] = 1'b0;
                end else begin
                    m_err = 1;
                end
            end
        end
        if (pick >= 0) begin
            m_rr = (pick + 1) % NPORTS;
            if (pick_eff == '0) m_drop[pick] = 1'b1;
            else begin
                m_grant[pick] = 1'b1;
                m_gmask = pick_eff;
                m_rem[pick] = pick_eff;
                for (int o = 0; o < NPORTS; o++)
                    if (pick_eff[o]) begin m_frame[o] = 1; m_owner[o] = pick; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("grant",      32'(bus_if.grant),      32'(m_grant));
        chk("grant_mask", 32'(bus_if.grant_mask), 32'(m_gmask));
        chk("drop",       32'(bus_if.drop),       32'(m_drop));
        chk("out_busy",   32'(bus_if.out_busy),   32'(m_busy(cyc)));
        chk("out_owner",  32'(bus_if.out_owner),  32'(m_owner_vec()));
        chk("err",        32'(bus_if.err),        32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_step();
        #1;
        bus_if.tx_done = '0;
        check_all();
        $display("cyc=%0d valid=%b grant=%b gmask=%b drop=%b busy=%b owner=%h err=%b",
                 cyc, bus_if.req_valid, bus_if.grant, bus_if.grant_mask, bus_if.drop,
                 bus_if.out_busy, bus_if.out_owner, bus_if.err);
    endtask

    task automatic set_req(input int i, input bit [NPORTS-1:0] m);
        bus_if.req_mask[i*NPORTS +: NPORTS] = m;
    endtask

    task automatic drain();
        bus_if.req_valid = '0;
        for (int k = 0; k < 100; k++) begin
            bit [NPORTS-1:0] fr = '0;
            for (int o = 0; o < NPORTS; o++) fr[o] = m_frame[o];
            if (fr == '0 && m_busy(cyc) == '0) break;
            bus_if.tx_done = fr;
            step();
        end
        chk("drain_idle", 32'(bus_if.out_busy), 32'd0);
    endtask

    initial begin
        int lat, n;
        bus_if.link_sync = '0; bus_if.req_valid = '0; bus_if.req_mask = '0; bus_if.tx_done = '0;
        model_reset();
        #2 reset = 1'b0;
        #10 check_all();
        bus_if.link_sync = 4'hF;

        // Contention on output 3 from inputs 0 and 2 with rr_ptr at 0.
        bus_if.req_valid = 4'b0101; set_req(0, 4'b1000); set_req(2, 4'b1000);
        @(negedge clk) reset = 1'b1;
        step();
        chk("cont_grant0", 32'(bus_if.grant), 32'h1);
        bus_if.req_valid = 4'b0100;
        repeat (3) step();
        bus_if.tx_done[3] = 1'b1;
        step();
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus_if.grant[2]) begin lat = k; break; end
        end
        chk("cont_latency", 32'(lat), 32'd13);
        drain();

        // Unicast 0 -> 1 and the inter-frame gap length.
        bus_if.req_valid = 4'b0001; set_req(0, 4'b0010);
        step();
        chk("uni_grant", 32'(bus_if.grant), 32'h1);
        chk("uni_gmask", 32'(bus_if.grant_mask), 32'h2);
        chk("uni_owner1", 32'(bus_if.out_owner[3:2]), 32'd0);
        bus_if.req_valid = '0;
        repeat (2) step();
        bus_if.tx_done[1] = 1'b1;
        step();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus_if.out_busy[1]) break;
            n++;
            step();
        end
        chk("uni_gap_len", 32'(n), 32'd12);

        // Broadcast from input 1 waits for output 2.
        bus_if.req_valid = 4'b0001; set_req(0, 4'b0100);
        step();
        bus_if.req_valid = 4'b0010; set_req(1, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bc_blocked", 32'(bus_if.grant), 32'h0);
        end
        bus_if.tx_done[2] = 1'b1;
        step();
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus_if.grant[1]) begin lat = k; break; end
        end
        chk("bc_latency", 32'(lat), 32'd13);
        chk("bc_gmask", 32'(bus_if.grant_mask), 32'hD);
        chk("bc_owner", 32'(bus_if.out_owner), 32'h51);
        bus_if.req_valid = '0;
        bus_if.tx_done = 4'b1101;
        step();
        drain();

        // Empty effective masks: self only, then link down.
        bus_if.req_valid = 4'b0001; set_req(0, 4'b0001);
        step();
        chk("drop_self", 32'(bus_if.drop), 32'h1);
        chk("drop_self_nogrant", 32'(bus_if.grant), 32'h0);
        set_req(0, 4'b0100); bus_if.link_sync = 4'b1011;
        step();
        chk("drop_link", 32'(bus_if.drop), 32'h1);
        chk("drop_link_busy", 32'(bus_if.out_busy), 32'h0);
        bus_if.link_sync = 4'hF; bus_if.req_valid = '0;
        step();

        // Spurious tx_done on an idle output.
        bus_if.tx_done[2] = 1'b1;
        step();
        chk("err_set", 32'(bus_if.err), 32'h1);
        bus_if.req_valid = 4'b0001; set_req(0, 4'b1000);
        step();
        chk("err_sched", 32'(bus_if.grant), 32'h1);
        bus_if.req_valid = '0;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            bus_if.req_valid = 4'($urandom);
            bus_if.req_mask  = 16'($urandom);
            bus_if.link_sync = ($urandom_range(7) == 0) ? 4'($urandom) : 4'hF;
            for (int o = 0; o < NPORTS; o++) begin
                if (m_frame[o] && $urandom_range(3) == 0)  bus_if.tx_done[o] = 1'b1;
                else if ($urandom_range(40) == 0)          bus_if.tx_done[o] = 1'b1;
            end
            step();
        end
        bus_if.link_sync = 4'hF;
        drain();

        // Reset while outputs 0, 1 and 3 are reserved.
        bus_if.req_valid = 4'b0100; set_req(2, 4'b1011);
        step();
        chk("rst_pre_busy", 32'(bus_if.out_busy), 32'hB);
        bus_if.req_valid = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_grant", 32'(bus_if.grant), 32'h0);
        chk("rst_gmask", 32'(bus_if.grant_mask), 32'h0);
        chk("rst_drop", 32'(bus_if.drop), 32'h0);
        chk("rst_busy", 32'(bus_if.out_busy), 32'h0);
        chk("rst_owner", 32'(bus_if.out_owner), 32'h0);
        chk("rst_err", 32'(bus_if.err), 32'h0);
        model_reset();
        bus_if.req_valid = 4'b1010; set_req(1, 4'b0001); set_req(3, 4'b0100);
        @(negedge clk) reset = 1'b1;
        step();
        chk("rst_first_grant", 32'(bus_if.grant), 32'h2);
        step();
        chk("rst_second_grant", 32'(bus_if.grant), 32'h8);
        bus_if.req_valid = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
